// File: rtl/multiplexing_scanner.sv
// multiplexing_scanner
// Scans one LED driver group for a single frame. Each multiplexing row is
// walked in turn: the scanner requests every driver output index (row_en, led)
// from the pixel fetch path over a valid/ready handshake, then pulses the
// driver latch, optionally blanks the row for BLANK_CYCLES, and moves on.
// After the last row it returns to IDLE and pulses frame_done.
//
// Optional feature macro: MUX_SCAN_BLANK_EN
//   defined   : a BLANK interval of BLANK_CYCLES follows every latch
//   undefined : the next row starts right after the latch (BLANK_CYCLES unused)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   single-cycle frame request, honoured only in IDLE
//   busy       out  high in every state except IDLE
//   row_en     out  one-hot active multiplexing row (zero in IDLE and BLANK)
//   led        out  driver output index of the current request
//   req_valid  out  (row_en, led) request valid
//   req_ready  in   consumer accepts the request
//   latch      out  one-cycle driver latch pulse
//   frame_done out  one-cycle pulse in the first IDLE cycle after a frame
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | issuing (row_en, led) requests for the current row
// LATCH | one-cycle latch pulse, row still enabled
// BLANK | row disabled while blank_cnt counts down

module multiplexing_scanner #(
    parameter int NB_LEDS_PER_GROUP = 16,
    parameter int NB_MUX_ROWS       = 4,
    parameter int BLANK_CYCLES      = 8,
    localparam int LED_WIDTH        = $clog2(NB_LEDS_PER_GROUP),
    localparam int ROW_WIDTH        = $clog2(NB_MUX_ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic [NB_MUX_ROWS-1:0] row_en,
    output logic [LED_WIDTH-1:0]   led,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic                   latch,
    output logic                   frame_done
);

    if (BLANK_CYCLES < 1) begin : g_blank_check
        $error("multiplexing_scanner: BLANK_CYCLES must be at least 1");
    end

    localparam logic [LED_WIDTH-1:0]   LED_LAST = LED_WIDTH'(NB_LEDS_PER_GROUP - 1);
    localparam logic [ROW_WIDTH-1:0]   ROW_LAST = ROW_WIDTH'(NB_MUX_ROWS - 1);
    localparam logic [NB_MUX_ROWS-1:0] ROW_ONE  = NB_MUX_ROWS'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, BLANK} state_t;

    state_t                 state, state_nxt;
    logic [ROW_WIDTH-1:0]   row_cnt, row_cnt_nxt;
    logic [LED_WIDTH-1:0]   led_cnt, led_cnt_nxt;
    logic                   row_done;
    logic                   busy_nxt, req_valid_nxt, latch_nxt, frame_done_nxt;
    logic [NB_MUX_ROWS-1:0] row_en_nxt;

`ifdef MUX_SCAN_BLANK_EN
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);
    logic [BLANK_W-1:0] blank_cnt, blank_cnt_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row_cnt    <= '0;
            led_cnt    <= '0;
            busy       <= 1'b0;
            row_en     <= '0;
            req_valid  <= 1'b0;
            latch      <= 1'b0;
            frame_done <= 1'b0;
`ifdef MUX_SCAN_BLANK_EN
            blank_cnt  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            row_cnt    <= row_cnt_nxt;
            led_cnt    <= led_cnt_nxt;
            busy       <= busy_nxt;
            row_en     <= row_en_nxt;
            req_valid  <= req_valid_nxt;
            latch      <= latch_nxt;
            frame_done <= frame_done_nxt;
`ifdef MUX_SCAN_BLANK_EN
            blank_cnt  <= blank_cnt_nxt;
`endif
        end
    end

    // led_cnt is itself a flop, so the index output is taken straight from it.
    assign led = led_cnt;

    always_comb begin
        state_nxt      = state;
        row_cnt_nxt    = row_cnt;
        led_cnt_nxt    = led_cnt;
        row_done       = 1'b0;
        frame_done_nxt = 1'b0;
`ifdef MUX_SCAN_BLANK_EN
        blank_cnt_nxt  = blank_cnt;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = SHIFT;
                    row_cnt_nxt = '0;
                    led_cnt_nxt = '0;
                end
            end
            SHIFT: begin
                // req_valid is high throughout SHIFT, so ready alone marks a transfer.
                if (req_ready) begin
                    if (led_cnt == LED_LAST) begin
                        led_cnt_nxt = '0;
                        state_nxt   = LATCH;
                    end else begin
                        led_cnt_nxt = led_cnt + LED_WIDTH'(1);
                    end
                end
            end
            LATCH: begin
`ifdef MUX_SCAN_BLANK_EN
                state_nxt     = BLANK;
                blank_cnt_nxt = BLANK_LOAD;
`else
                row_done      = 1'b1;
`endif
            end
`ifdef MUX_SCAN_BLANK_EN
            BLANK: begin
                if (blank_cnt == '0) begin
                    row_done = 1'b1;
                end else begin
                    blank_cnt_nxt = blank_cnt - BLANK_W'(1);
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        if (row_done) begin
            if (row_cnt == ROW_LAST) begin
                state_nxt      = IDLE;
                row_cnt_nxt    = '0;
                frame_done_nxt = 1'b1;
            end else begin
                state_nxt   = SHIFT;
                row_cnt_nxt = row_cnt + ROW_WIDTH'(1);
            end
        end

        // Outputs are decoded from the next state so that they leave the flops
        // aligned with the state they describe.
        busy_nxt      = (state_nxt != IDLE);
        req_valid_nxt = (state_nxt == SHIFT);
        latch_nxt     = (state_nxt == LATCH);
        row_en_nxt    = '0;
        if (state_nxt == SHIFT || state_nxt == LATCH) begin
            row_en_nxt = ROW_ONE << row_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_multiplexing_scanner.sv
module tb_multiplexing_scanner;

    localparam int NL = 16;
    localparam int NR = 4;
    localparam int BC = 8;
`ifdef MUX_SCAN_BLANK_EN
    localparam int ROW_CYC = NL + 1 + BC;
`else
    localparam int ROW_CYC = NL + 1;
`endif
    localparam int FRAME = NR * ROW_CYC + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       req_ready;
    logic       busy;
    logic [3:0] row_en;
    logic [3:0] led;
    logic       req_valid;
    logic       latch;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplexing_scanner #(
        .NB_LEDS_PER_GROUP(NL),
        .NB_MUX_ROWS      (NR),
        .BLANK_CYCLES     (BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .row_en    (row_en),
        .led       (led),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .latch     (latch),
        .frame_done(frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        start     = 1'b0;
        req_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Expected {busy, row_en, led, req_valid, latch, frame_done} for cycle c,
    // where cycle 0 is the cycle in which the first start is sampled.
    // mode: 0 single pulse, 1 extra pulse at cycle 50, 2 start held high.
    function automatic logic [11:0] exp_vec(input int c, input int mode, input int rst_at,
                                            input int s, input int len);
        int e, r, p;
        logic b, v, l, f;
        logic [3:0] re, ld;
        b = 1'b0; v = 1'b0; l = 1'b0; f = 1'b0; re = 4'h0; ld = 4'h0;
        if (rst_at > 0 && c > rst_at) return 12'h000;
        e = c;
        if (mode == 2 && c >= 1) e = ((c - 1) % FRAME) + 1;
        if (len > 0) begin
            if (c > s && c <= s + len) e = s;
            else if (c > s + len) e = c - len;
        end
        if (e >= 1 && e <= NR * ROW_CYC) begin
            r = (e - 1) / ROW_CYC;
            p = (e - 1) % ROW_CYC;
            b = 1'b1;
            if (p < NL) begin
                v  = 1'b1;
                re = 4'b0001 << r;
                ld = 4'(p);
            end else if (p == NL) begin
                l  = 1'b1;
                re = 4'b0001 << r;
            end
        end else if (e == FRAME) begin
            f = 1'b1;
        end
        return {b, re, ld, v, l, f};
    endfunction

    task automatic run(input int n, input int mode, input int rst_at, input int s,
                       input int len, input int exp_fd_cyc, input int exp_fd_cnt,
                       input bit chk_xfer);
        int xfers = 0;
        int fd_cnt = 0;
        int fd_first = -1;
        int fd_last = -1;
        logic [11:0] obs;
        logic [3:0] er;
        for (int c = 0; c <= n; c++) begin
            start     = (c == 0) || (mode == 1 && c == 50) || (mode == 2);
            rst       = (rst_at > 0 && c == rst_at);
            req_ready = !(len > 0 && c >= s && c < s + len);
            obs = {busy, row_en, led, req_valid, latch, frame_done};
            chk($sformatf("cyc%0d_mode%0d", c, mode), 32'(obs),
                32'(exp_vec(c, mode, rst_at, s, len)));
            if (len > 0 && c == s + len - 1)
                chk("stall_hold", {row_en, led, req_valid}, {4'b0010, 4'd5, 1'b1});
            if (req_valid && req_ready) begin
                if (chk_xfer) begin
                    er = 4'b0001 << (xfers / NL);
                    chk($sformatf("xfer%0d", xfers), {row_en, led}, {er, 4'(xfers % NL)});
                end
                xfers++;
            end
            if (frame_done) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = c;
                fd_last = c;
            end
            step();
        end
        start     = 1'b0;
        rst       = 1'b0;
        req_ready = 1'b1;
        chk("fd_count", fd_cnt, exp_fd_cnt);
        if (exp_fd_cnt > 0) chk("fd_cycle", fd_first, exp_fd_cyc);
        if (exp_fd_cnt > 1) chk("fd_period", fd_last - fd_first, FRAME);
        if (chk_xfer) chk("xfer_total", xfers, NL * NR);
    endtask

    initial begin
        apply_reset();
        rst = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_row_en", row_en, 4'h0);
        chk("rst_led", led, 4'h0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_latch", latch, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;

        // plain frame
        run(FRAME + 4, 0, 0, 0, 0, FRAME, 1, 1'b1);

        // 3-cycle stall at row 1, led 5
        apply_reset();
        run(FRAME + 7, 0, 0, 1 + ROW_CYC + 5, 3, FRAME + 3, 1, 1'b1);

        // start while busy is ignored
        apply_reset();
        run(FRAME + 4, 1, 0, 0, 0, FRAME, 1, 1'b1);

        // reset mid-row, then restart from row 0 led 0
        apply_reset();
        run(40, 0, 30, 0, 0, 0, 0, 1'b0);
        run(FRAME + 4, 0, 0, 0, 0, FRAME, 1, 1'b1);

        // start held high: back-to-back frames
        apply_reset();
        run(2 * FRAME + 3, 2, 0, 0, 0, FRAME, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplexing_scanner.md
# multiplexing_scanner

Sequencer that drives the LED multiplexing scan for one driver group. On `start` it walks every multiplexing row and, within each row, every driver output index. It emits `(row_en, led)` address requests over a valid/ready handshake to the pixel fetch path; that path resolves them to a LED row height through the multiplexing lookup. After each row it issues a driver latch pulse and an optional blanking interval, and reports frame completion.

## Interface
Parameters:
- `NB_LEDS_PER_GROUP`, 16, driver outputs per group; `LED_WIDTH = $clog2(NB_LEDS_PER_GROUP)`.
- `NB_MUX_ROWS`, 4, multiplexing rows; `ROW_WIDTH = $clog2(NB_MUX_ROWS)`.
- `BLANK_CYCLES`, 8, blanking length after each latch. Must be ≥ 1.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: single-cycle request to scan one frame. Ignored unless IDLE.
- `busy` output 1: high in every state except IDLE.
- `row_en` output NB_MUX_ROWS: one-hot active multiplexing row. All-zero in IDLE and BLANK.
- `led` output LED_WIDTH: driver output index of the current request.
- `req_valid` output 1: request `(row_en, led)` is valid.
- `req_ready` input 1: consumer accepts the request. Transfer occurs when `req_valid && req_ready`.
- `latch` output 1: one-cycle pulse to latch the driver shift registers.
- `frame_done` output 1: one-cycle pulse when the frame completes.

## Operation
- States: IDLE, SHIFT, LATCH, BLANK. Counters: `row_cnt` (ROW_WIDTH), `led_cnt` (LED_WIDTH), `blank_cnt` (`$clog2(BLANK_CYCLES+1)`).
- IDLE + `start` → SHIFT. `row_cnt` = 0, `led_cnt` = 0.
- SHIFT:
  - `req_valid` = 1; `row_en` = 1 << `row_cnt`; `led` = `led_cnt`.
  - On transfer: `led_cnt` increments.
  - On transfer with `led_cnt` = NB_LEDS_PER_GROUP-1: `led_cnt` wraps to 0 and the state goes to LATCH.
- LATCH: `latch` = 1 for exactly one cycle; `row_en` still holds the current row; `req_valid` = 0.
  - Next state is BLANK, with `blank_cnt` loaded to BLANK_CYCLES-1.
- BLANK: `row_en` = 0; `blank_cnt` decrements.
  - At 0, if `row_cnt` = NB_MUX_ROWS-1: go to IDLE, pulse `frame_done` in the first IDLE cycle, and clear `row_cnt`.
  - At 0, otherwise: increment `row_cnt` and go to SHIFT.
- Handshake rules:
  - While `req_valid` is high and `req_ready` is low, `row_en` and `led` are held stable.
  - `req_valid` never drops without a transfer.
  - `req_ready` is ignored outside SHIFT.
- `start` while busy: ignored, no queuing.
- `start` in the cycle `frame_done` is high: accepted (the state is IDLE).
- `rst` at any point, including mid-row: next cycle is IDLE with all counters 0. Pending requests are dropped; no `latch` or `frame_done` pulse is issued.
- Reset values: `busy`=0, `row_en`=0, `led`=0, `req_valid`=0, `latch`=0, `frame_done`=0.
- All outputs are registered.

## Timing
- `start` sampled high in cycle 0 → `req_valid`=1 with `row_en`=0001 and `led`=0 in cycle 1.
- With `req_ready` held high, per row: NB_LEDS_PER_GROUP SHIFT cycles, 1 LATCH cycle, BLANK_CYCLES BLANK cycles.
  - Defaults: 25 cycles per row.
  - Row k's first request is in cycle 1+25k.
  - `frame_done` is in cycle 101.
- Each cycle with `req_ready` low in SHIFT adds exactly one cycle of latency.
- `busy` rises in cycle 1 and falls in the `frame_done` cycle.

## Configuration
- `MUX_SCAN_BLANK_EN` defined: BLANK state present as described above.
- Not defined: no BLANK state. LATCH goes directly to SHIFT of the next row, or to IDLE/`frame_done` after the last row. `row_en` is never zero between rows.
  - Defaults: 17 cycles per row; `frame_done` in cycle 69.
  - BLANK_CYCLES is unused.

## Test plan
- Default parameters, blanking enabled, `req_ready`=1, `start` pulse in cycle 0:
  - 64 transfers, in order (row 0, led 0..15) … (row 3, led 0..15).
  - `latch` in cycles 17, 42, 67, 92.
  - `row_en`=0 in cycles 18–25.
  - `frame_done` only in cycle 101.
- `req_ready` low for 3 cycles at row 1, led 5:
  - `row_en`=0010 and `led`=5 held for the whole stall, with `req_valid` high.
  - `frame_done` moves to cycle 104.
- `start` pulsed again in cycle 50: no effect; a single `frame_done` in cycle 101.
- `rst` asserted in cycle 30 (row 1, SHIFT): all outputs at reset values from cycle 31; `frame_done` never asserted. A new `start` then restarts at row 0, led 0.
- `start` held high continuously: back-to-back frames. The second frame's first request is in cycle 102, and `frame_done` recurs every 101 cycles.
- `MUX_SCAN_BLANK_EN` undefined, `req_ready`=1:
  - `latch` in cycles 17, 34, 51, 68.
  - `row_en` never all-zero between cycles 1 and 68.
  - `frame_done` in cycle 69.
